// File: rtl/mem_arb2.sv
// mem_arb2: two-master burst command arbiter in front of the mi_* port.
// Records the owner of every accepted burst in a per-direction owner queue
// and uses the queue heads to send write acks and read strobes back to the
// master that issued the burst.
module mem_arb2 #(
  parameter int AW = 20,
  parameter int QD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [6:0]    m0_len,
  input  logic          m0_rw,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [31:0]   m0_wdata,
  output logic          m0_wack,
  output logic          m0_wlast,
  output logic [31:0]   m0_rdata,
  output logic          m0_rstb,
  output logic          m0_rlast,
  input  logic [AW-1:0] m1_addr,
  input  logic [6:0]    m1_len,
  input  logic          m1_rw,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [31:0]   m1_wdata,
  output logic          m1_wack,
  output logic          m1_wlast,
  output logic [31:0]   m1_rdata,
  output logic          m1_rstb,
  output logic          m1_rlast,
  output logic [AW-1:0] mi_addr,
  output logic [6:0]    mi_len,
  output logic          mi_rw,
  output logic          mi_valid,
  input  logic          mi_ready,
  output logic [31:0]   mi_wdata,
  input  logic          mi_wack,
  input  logic          mi_wlast,
  input  logic [31:0]   mi_rdata,
  input  logic          mi_rstb,
  input  logic          mi_rlast,
  output logic          err
);

  localparam int PW = $clog2(QD);
  localparam int CW = PW + 1;

  logic          prio, lock, gnt_q, gnt;
  logic [QD-1:0] wq_mem, rq_mem;
  logic [PW-1:0] wq_hd, wq_tl, rq_hd, rq_tl;
  logic [CW-1:0] wq_cnt, rq_cnt;
  logic          wq_full, rq_full, wq_empty, rq_empty;
  logic          elig0, elig1, sel_valid, sel_rw, sel_full;
  logic          hs, wpush, rpush, wpop, rpop;
  logic          w_own, r_own, wv, rv;

  assign wq_full  = (wq_cnt == CW'(QD));
  assign rq_full  = (rq_cnt == CW'(QD));
  assign wq_empty = (wq_cnt == '0);
  assign rq_empty = (rq_cnt == '0);

  // A master is only a candidate when its direction's owner queue has room,
  // so a blocked master never starves the other one while nothing is offered.
  assign elig0 = m0_valid && !(m0_rw ? rq_full : wq_full);
  assign elig1 = m1_valid && !(m1_rw ? rq_full : wq_full);

  // Grant select: hold the offered command while it is stalled, else round-robin.
  always_comb begin
    gnt = 1'b0;
    if (lock)                gnt = gnt_q;
    else if (elig0 && elig1) gnt = prio;
    else if (elig1)          gnt = 1'b1;
    else                     gnt = 1'b0;
  end

  assign sel_valid = gnt ? m1_valid : m0_valid;
  assign sel_rw    = gnt ? m1_rw    : m0_rw;
  assign sel_full  = sel_rw ? rq_full : wq_full;

  assign mi_valid = !rst && sel_valid && !sel_full;
  assign mi_addr  = rst ? '0 : (gnt ? m1_addr : m0_addr);
  assign mi_len   = rst ? '0 : (gnt ? m1_len  : m0_len);
  assign mi_rw    = !rst && sel_rw;

  assign hs       = mi_valid && mi_ready;
  assign m0_ready = hs && !gnt;
  assign m1_ready = hs && gnt;
  assign wpush    = hs && !sel_rw;
  assign rpush    = hs && sel_rw;
  assign wpop     = mi_wack && mi_wlast && !wq_empty;
  assign rpop     = mi_rstb && mi_rlast && !rq_empty;

  // Arbitration state: round-robin pointer and stall lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio  <= 1'b0;
      lock  <= 1'b0;
      gnt_q <= 1'b0;
    end else begin
      lock  <= mi_valid && !mi_ready;
      gnt_q <= gnt;
      if (hs) prio <= ~gnt;
    end
  end

  // Write owner queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wq_mem <= '0;
      wq_hd  <= '0;
      wq_tl  <= '0;
      wq_cnt <= '0;
    end else begin
      if (wpush) begin
        wq_mem[wq_tl] <= gnt;
        wq_tl         <= wq_tl + PW'(1);
      end
      if (wpop) wq_hd <= wq_hd + PW'(1);
      if (wpush && !wpop)      wq_cnt <= wq_cnt + CW'(1);
      else if (!wpush && wpop) wq_cnt <= wq_cnt - CW'(1);
    end
  end

  // Read owner queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_mem <= '0;
      rq_hd  <= '0;
      rq_tl  <= '0;
      rq_cnt <= '0;
    end else begin
      if (rpush) begin
        rq_mem[rq_tl] <= gnt;
        rq_tl         <= rq_tl + PW'(1);
      end
      if (rpop) rq_hd <= rq_hd + PW'(1);
      if (rpush && !rpop)      rq_cnt <= rq_cnt + CW'(1);
      else if (!rpush && rpop) rq_cnt <= rq_cnt - CW'(1);
    end
  end

  // Data routing by queue head; an empty queue routes nowhere.
  assign w_own = wq_mem[wq_hd];
  assign r_own = rq_mem[rq_hd];
  assign wv    = mi_wack && !wq_empty;
  assign rv    = mi_rstb && !rq_empty;

  assign m0_wack  = wv && !w_own;
  assign m1_wack  = wv && w_own;
  assign m0_wlast = m0_wack && mi_wlast;
  assign m1_wlast = m1_wack && mi_wlast;
  assign mi_wdata = wq_empty ? '0 : (w_own ? m1_wdata : m0_wdata);

  assign m0_rstb  = rv && !r_own;
  assign m1_rstb  = rv && r_own;
  assign m0_rlast = m0_rstb && mi_rlast;
  assign m1_rlast = m1_rstb && mi_rlast;
  assign m0_rdata = m0_rstb ? mi_rdata : '0;
  assign m1_rdata = m1_rstb ? mi_rdata : '0;

  // Sticky error on a strobe that has no owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          err <= 1'b0;
    else if ((mi_wack && wq_empty) || (mi_rstb && rq_empty)) err <= 1'b1;
  end

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-master command arbiter and data router in front of the memory controller `mi_*` interface. It multiplexes burst commands from two upstream requesters, such as a cache refill engine and a DMA engine, onto one `mi_*` port. It tracks which master owns each accepted burst, so the controller's write-acknowledge and read-strobe streams are steered back to the correct master. Multiple commands may be outstanding.

## Interface
Parameters:
- `AW`, 20: address width in 32-bit words (`AL = AW-1`).
- `QD`, 4: depth of each owner queue; a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `m0_addr` / `m1_addr`  in  AW  burst start address.
- `m0_len` / `m1_len`  in  7  burst length; `len` means `len+1` words.
- `m0_rw` / `m1_rw`  in  1  1 = read, 0 = write.
- `m0_valid` / `m1_valid`  in  1  command request.
- `m0_ready` / `m1_ready`  out  1  command accepted this cycle.
- `m0_wdata` / `m1_wdata`  in  32  write word; must be valid in the cycle the master's `wack` is high.
- `m0_wack`, `m0_wlast` / `m1_wack`, `m1_wlast`  out  1  routed write acknowledge and last-word flag.
- `m0_rdata` / `m1_rdata`  out  32  routed read data.
- `m0_rstb`, `m0_rlast` / `m1_rstb`, `m1_rlast`  out  1  routed read strobe and last-word flag.
- `mi_addr`, `mi_len`, `mi_rw`, `mi_valid`  out  downstream command.
- `mi_ready`  in  1  downstream command accept.
- `mi_wdata`  out  32  downstream write data.
- `mi_wack`, `mi_wlast`  in  1  downstream write acknowledge and last flag.
- `mi_rdata`  in  32  downstream read data.
- `mi_rstb`, `mi_rlast`  in  1  downstream read strobe and last flag.
- `err`  out  1  sticky protocol-error flag.

## Operation
Command arbitration:
- Round-robin between the two masters.
- `prio` register: 0 favours m0, 1 favours m1.
- Grant selection:
  - If only one master is requesting, it is granted.
  - If both request, `prio` decides.
  - The grant is locked while `mi_valid && !mi_ready`. A command presented downstream never changes until it is accepted.
- Gating by owner queue:
  - `mi_valid` = granted `mX_valid` AND the owner queue for its direction (write or read, chosen by `mX_rw`) is not full.
  - `mi_addr`, `mi_len`, `mi_rw` are muxed from the granted master.
- Handshake:
  - `mX_ready` = `mi_valid && mi_ready && grant==X`.
  - On a handshake, `prio` is set to the non-granted master.
  - On a handshake, the master index is pushed into the write queue (`rw=0`) or the read queue (`rw=1`).
  - Masters must hold their command stable until `mX_ready`.

Owner queues:
- There are two FIFOs, each `QD` deep and 1 bit wide: `wq` and `rq`.
- Each has a head pointer, a tail pointer and a count that is `log2(QD)+1` bits wide.
- Pointers wrap modulo `QD`.

Write routing:
- `mX_wack` = `mi_wack && !wq_empty && wq_head==X`; `mX_wlast` is routed the same way.
- `mi_wdata` = `wdata` of the `wq_head` master, or 0 when `wq` is empty.
- `wq` pops on `mi_wack && mi_wlast`.

Read routing:
- `mX_rstb` = `mi_rstb && !rq_empty && rq_head==X`; `mX_rlast` is routed the same way.
- `mX_rdata` = `mi_rdata` whenever `mX_rstb` is high, and 0 otherwise.
- `rq` pops on `mi_rstb && mi_rlast`.

Boundary conditions:
- Queue full: a command in that direction is not offered downstream, even if a pop happens in the same cycle. The other master's command in the other direction may be granted instead; this lock-free re-selection is allowed only while `mi_valid` is low.
- Push and pop in the same cycle on a non-full queue: the count is unchanged and both pointers advance.
- `mi_wack` with `wq` empty, or `mi_rstb` with `rq` empty:
  - No master-side strobe is asserted.
  - `err` is set to 1 and holds until reset.

Reset, including mid-burst:
- Both queues are emptied.
- `prio` = 0, `err` = 0, the grant lock is cleared.
- In-flight bursts are abandoned; any later strobes for them set `err`.

## Timing
- Command path is combinational: 0-cycle latency from `mX_valid` to `mi_valid`, and from `mi_ready` to `mX_ready`.
- Data routing is combinational from `mi_wack` / `mi_rstb` to the master strobes.
- Queue push and pop take effect at the next edge. A command accepted in cycle N is routable from cycle N+1; downstream strobes never arrive earlier than that.
- During and immediately after reset:
  - `m0_ready`, `m1_ready`, all `wack` / `wlast` / `rstb` / `rlast` outputs and `mi_valid` are 0.
  - All data outputs are 0.
  - `err` is 0.

## Test plan
- **Single read.** m0 requests `addr=0x100`, `len=3`, `rw=1` with an idle controller.
  - `m0_ready` pulses once.
  - 4 `m0_rstb` pulses carry `mem[0x100..0x103]`; `m0_rlast` is on the 4th.
  - `m1_rstb` stays 0.
- **Contention.** Both masters hold writes (`len=0`) continuously.
  - Grants alternate m0, m1, m0, m1.
  - Each `mX_wack` lands on the owner whose command was accepted, and the written words match `mX_wdata`.
- **Interleaved directions.** m1 issues a write (`len=7`), then m0 a read (`len=1`), back-to-back.
  - 8 `wack` pulses go to m1; 2 `rstb` pulses go to m0.
  - Both queues are empty afterwards.
- **Queue full.** The controller stalls read data; 4 read commands are accepted.
  - The 5th read keeps `mi_valid` = 0.
  - After the first `rlast` pop, the 5th read is accepted the following cycle.
- **Spurious strobe.** Drive `mi_rstb` = 1 with `rq` empty.
  - No master `rstb` is asserted.
  - `err` = 1 and persists until `rst`.
- **Reset mid-burst.** Assert `rst` during a `len=15` read.
  - All outputs go to 0 immediately; queues are empty.
  - A fresh m1 command is served normally after reset.
